trap_ctrl: RTL and testbench
============================

# trap_ctrl

Trap controller for the commit stage of the core. It detects synchronous exceptions, machine interrupts and `mret` on the committing instruction. It sequences pipeline flush, the one-cycle trap-state write-back into the CSR file and the PC redirect. It drives the CSR file's exception write port: `we_exc`, `mcause`, `mepc`, `mtval`, `mstatus` and `sel_exc_nret`.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 2: number of cycles `flush_o` is held before the CSR write (1..7).

Ports:
- `clk_i`  in  1  core clock
- `rst_i`  in  1  reset, asynchronous, active-low
- `valid_i`  in  1  committing instruction valid
- `pc_i`  in  32  PC of committing instruction
- `instr_i`  in  32  instruction word
- `addr_i`  in  32  faulting address (branch target or load/store EA)
- `exc_fetch_mis_i`, `exc_illegal_i`, `exc_ecall_i`, `exc_ebreak_i`, `exc_load_mis_i`, `exc_store_mis_i`  in  1 each  exception flags
- `mret_i`  in  1  committing instruction is `mret`
- `irq_ext_i`, `irq_sw_i`, `irq_tmr_i`  in  1 each  level interrupt requests
- `mstatus_i`, `mie_i`, `mepc_i`, `mcause_i`, `mtval_i`  in  32 each  current CSR values
- `we_exc_o`  out  1  CSR exception write strobe
- `mcause_o`, `mepc_o`, `mtval_o`, `mstatus_o`  out  32 each  CSR write data
- `sel_exc_nret_o`  out  1  0 selects `mtvec` (trap), 1 selects `mepc` (return)
- `flush_o`  out  1  kill younger pipeline stages
- `busy_o`  out  1  stall commit; high in every non-IDLE state
- `redirect_o`  out  1  fetch loads the CSR return/vector address this cycle

## Operation
- FSM states: IDLE, FLUSH, COMMIT, REDIRECT.
- IDLE: an event is accepted only if `valid_i`=1.
- Event priority for the same instruction: `exc_fetch_mis`(cause 0) > `exc_illegal`(2) > `exc_ecall`(11) > `exc_ebreak`(3) > `exc_load_mis`(4) > `exc_store_mis`(6) > interrupt > `mret`.
- Interrupt pending when `mstatus_i[3]` (MIE) = 1 and the line and its `mie_i` bit (11/3/7) are set.
  - Interrupt priority is ext(11) > sw(3) > tmr(7).
  - `mcause` = {1'b1, 27'b0, code}.
- On acceptance, all write data is latched in IDLE and held until IDLE returns.
- Exception:
  - `mepc` = `pc_i`; `mcause` = {1'b0, code}.
  - `mtval` = `addr_i` for misaligned causes, `instr_i` for illegal, `pc_i` for ebreak, 0 for ecall.
  - `sel_exc_nret`=0.
- Interrupt: `mepc` = `pc_i` (instruction not executed); `mtval` = 0; `sel_exc_nret`=0.
- Trap `mstatus`: MPIE[7] ← MIE[3], MIE ← 0, MPP[12:11] ← 2'b11; other bits from `mstatus_i`.
- `mret`:
  - `mepc`/`mcause`/`mtval` rewritten with `mepc_i`/`mcause_i`/`mtval_i` (unchanged).
  - `mstatus`: MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
  - `sel_exc_nret`=1.
- Transitions: IDLE→FLUSH on accept; FLUSH→COMMIT after `DRAIN_CYCLES` cycles; COMMIT→REDIRECT; REDIRECT→IDLE.
- Inputs are ignored outside IDLE. Interrupt lines still asserted are re-evaluated on return to IDLE.

## Timing
- Reset: state IDLE; every output 0. Reset asserted mid-sequence aborts immediately, with no `we_exc_o` pulse.
- Cycle 0 (IDLE, event sampled): all outputs still 0; data latched at the clock edge.
- Cycles 1..`DRAIN_CYCLES`: `flush_o`=1, `busy_o`=1.
- Cycle `DRAIN_CYCLES`+1 (COMMIT): `we_exc_o`=1 for exactly one cycle, `busy_o`=1, write data valid.
- Cycle `DRAIN_CYCLES`+2 (REDIRECT): `redirect_o`=1 for one cycle and `sel_exc_nret_o` valid; the CSR return address reflects the COMMIT write.
- Total busy: `DRAIN_CYCLES`+2 cycles. A new event is accepted earliest in the cycle after REDIRECT.
- Write data and `sel_exc_nret_o` hold their latched values from cycle 1 through REDIRECT; they return to 0 in IDLE.

## Configuration
- `TRAP_IRQ_EN` defined: interrupt detection as above.
- Undefined:
  - `irq_*_i` and `mie_i` are ignored, and no interrupt cause is ever generated.
  - Exceptions and `mret` behave unchanged.

## Test plan
- Illegal instruction: `pc_i`=0x100, `instr_i`=0xFFFFFFFF, `mstatus_i`=0x8 -> after 2 flush cycles, `we_exc_o` pulses once with `mcause_o`=2, `mepc_o`=0x100, `mtval_o`=0xFFFFFFFF, `mstatus_o`=0x1880; next cycle `redirect_o`=1, `sel_exc_nret_o`=0.
- Ecall together with load misaligned on the same instruction -> `mcause_o`=11, `mtval_o`=0.
- `mret` with `mstatus_i`=0x1880, `mepc_i`=0x204 -> `mstatus_o`=0x1888, `mepc_o`=0x204, `sel_exc_nret_o`=1 in COMMIT and REDIRECT.
- `TRAP_IRQ_EN`, `irq_tmr_i`=`irq_ext_i`=1, `mie_i`=0x880, MIE=1 -> `mcause_o`=0x8000000B.
- Same interrupt stimulus with MIE=0, or with the macro undefined -> no sequence, `busy_o` stays 0.
- Reset pulsed during FLUSH -> all outputs 0 in the next cycle, no `we_exc_o` pulse; a new event after release runs the full `DRAIN_CYCLES`+2 sequence.

Source files
------------

// File: rtl/trap_ctrl.sv
// Commit-stage trap controller: flush, one-cycle CSR trap-state write, PC redirect.
// Define TRAP_IRQ_EN to enable machine interrupt detection; default build handles exceptions and mret only.
module trap_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] addr_i,
    input  logic        exc_fetch_mis_i,
    input  logic        exc_illegal_i,
    input  logic        exc_ecall_i,
    input  logic        exc_ebreak_i,
    input  logic        exc_load_mis_i,
    input  logic        exc_store_mis_i,
    input  logic        mret_i,
    input  logic        irq_ext_i,
    input  logic        irq_sw_i,
    input  logic        irq_tmr_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mcause_i,
    input  logic [31:0] mtval_i,
    output logic        we_exc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mtval_o,
    output logic [31:0] mstatus_o,
    output logic        sel_exc_nret_o,
    output logic        flush_o,
    output logic        busy_o,
    output logic        redirect_o
);

    // state    | meaning
    // IDLE     | waiting for a valid committing instruction with an event
    // FLUSH    | killing younger stages for DRAIN_CYCLES cycles
    // COMMIT   | one-cycle CSR trap-state write
    // REDIRECT | fetch loads mtvec/mepc
    typedef enum logic [1:0] {IDLE, FLUSH, COMMIT, REDIRECT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [31:0] cause_q, epc_q, tval_q, status_q;
    logic        sel_q;
    logic [31:0] cause_d, epc_d, tval_d, status_d;
    logic        sel_d;
    logic        exc_any, irq_any, accept;
    logic [3:0]  irq_code;
    logic        irq_ext, irq_sw, irq_tmr;
    logic        unused_ok;

`ifdef TRAP_IRQ_EN
    assign irq_ext = mstatus_i[3] & irq_ext_i & mie_i[11];
    assign irq_sw  = mstatus_i[3] & irq_sw_i  & mie_i[3];
    assign irq_tmr = mstatus_i[3] & irq_tmr_i & mie_i[7];
`else
    assign irq_ext = 1'b0;
    assign irq_sw  = 1'b0;
    assign irq_tmr = 1'b0;
`endif
    assign unused_ok = ^{mie_i, irq_ext_i, irq_sw_i, irq_tmr_i};

    assign irq_any  = irq_ext | irq_sw | irq_tmr;
    assign irq_code = irq_ext ? 4'd11 : (irq_sw ? 4'd3 : 4'd7);
    assign exc_any  = exc_fetch_mis_i | exc_illegal_i | exc_ecall_i
                    | exc_ebreak_i | exc_load_mis_i | exc_store_mis_i;
    assign accept   = valid_i & (exc_any | irq_any | mret_i);

    always_comb begin
        cause_d          = '0;
        tval_d           = '0;
        epc_d            = pc_i;
        sel_d            = 1'b0;
        status_d         = mstatus_i;
        status_d[7]      = mstatus_i[3];
        status_d[3]      = 1'b0;
        status_d[12:11]  = 2'b11;
        if (exc_fetch_mis_i) begin
            cause_d = 32'd0;
            tval_d  = addr_i;
        end else if (exc_illegal_i) begin
            cause_d = 32'd2;
            tval_d  = instr_i;
        end else if (exc_ecall_i) begin
            cause_d = 32'd11;
        end else if (exc_ebreak_i) begin
            cause_d = 32'd3;
            tval_d  = pc_i;
        end else if (exc_load_mis_i) begin
            cause_d = 32'd4;
            tval_d  = addr_i;
        end else if (exc_store_mis_i) begin
            cause_d = 32'd6;
            tval_d  = addr_i;
        end else if (irq_any) begin
            cause_d = {1'b1, 27'b0, irq_code};
        end else begin
            // mret: trap CSRs are rewritten with their current values
            epc_d           = mepc_i;
            cause_d         = mcause_i;
            tval_d          = mtval_i;
            status_d        = mstatus_i;
            status_d[3]     = mstatus_i[7];
            status_d[7]     = 1'b1;
            status_d[12:11] = 2'b11;
            sel_d           = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = 3'(DRAIN_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt == 3'd0) state_nxt = COMMIT;
                else             cnt_nxt   = cnt - 3'd1;
            end
            COMMIT:   state_nxt = REDIRECT;
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            cause_q  <= '0;
            epc_q    <= '0;
            tval_q   <= '0;
            status_q <= '0;
            sel_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && accept) begin
                cause_q  <= cause_d;
                epc_q    <= epc_d;
                tval_q   <= tval_d;
                status_q <= status_d;
                sel_q    <= sel_d;
            end
        end
    end

    // write data is only visible while a sequence is in flight
    assign busy_o         = (state != IDLE);
    assign flush_o        = (state == FLUSH);
    assign we_exc_o       = (state == COMMIT);
    assign redirect_o     = (state == REDIRECT);
    assign mcause_o       = busy_o ? cause_q  : '0;
    assign mepc_o         = busy_o ? epc_q    : '0;
    assign mtval_o        = busy_o ? tval_q   : '0;
    assign mstatus_o      = busy_o ? status_q : '0;
    assign sel_exc_nret_o = busy_o & sel_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized bench for trap_ctrl against a behavioural trap model.
module tb_trap_ctrl;
    localparam int D = 2;
    localparam int EXC_CODE [6] = '{0, 2, 11, 3, 4, 6};
    localparam int IRQ_CODE [3] = '{11, 3, 7};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid;
    logic [31:0] pc, instr, addr, mstatus, mie, mepc, mcause, mtval;
    logic fetch_mis, illegal, ecall, ebreak, load_mis, store_mis, mret;
    logic irq_ext, irq_sw, irq_tmr;
    logic we_exc, sel_exc_nret, flush, busy, redirect;
    logic [31:0] mcause_q, mepc_q, mtval_q, mstatus_q;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.DRAIN_CYCLES(D)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc), .instr_i(instr),
        .addr_i(addr), .exc_fetch_mis_i(fetch_mis), .exc_illegal_i(illegal),
        .exc_ecall_i(ecall), .exc_ebreak_i(ebreak), .exc_load_mis_i(load_mis),
        .exc_store_mis_i(store_mis), .mret_i(mret), .irq_ext_i(irq_ext),
        .irq_sw_i(irq_sw), .irq_tmr_i(irq_tmr), .mstatus_i(mstatus), .mie_i(mie),
        .mepc_i(mepc), .mcause_i(mcause), .mtval_i(mtval), .we_exc_o(we_exc),
        .mcause_o(mcause_q), .mepc_o(mepc_q), .mtval_o(mtval_q),
        .mstatus_o(mstatus_q), .sel_exc_nret_o(sel_exc_nret), .flush_o(flush),
        .busy_o(busy), .redirect_o(redirect)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        valid = 0; pc = 0; instr = 0; addr = 0; mstatus = 0; mie = 0;
        mepc = 0; mcause = 0; mtval = 0; fetch_mis = 0; illegal = 0; ecall = 0;
        ebreak = 0; load_mis = 0; store_mis = 0; mret = 0;
        irq_ext = 0; irq_sw = 0; irq_tmr = 0;
    endtask

    task automatic rand_inputs();
        valid     = ($urandom_range(0, 9) < 8);
        pc        = $urandom; instr = $urandom; addr = $urandom;
        mstatus   = $urandom; mie = $urandom; mepc = $urandom;
        mcause    = $urandom; mtval = $urandom;
        fetch_mis = ($urandom_range(0, 9) == 0);
        illegal   = ($urandom_range(0, 7) == 0);
        ecall     = ($urandom_range(0, 7) == 0);
        ebreak    = ($urandom_range(0, 7) == 0);
        load_mis  = ($urandom_range(0, 7) == 0);
        store_mis = ($urandom_range(0, 7) == 0);
        mret      = ($urandom_range(0, 2) == 0);
        irq_ext   = ($urandom_range(0, 2) == 0);
        irq_sw    = ($urandom_range(0, 2) == 0);
        irq_tmr   = ($urandom_range(0, 2) == 0);
    endtask

    // Reference: pick the highest-priority event from ordered lists.
    function automatic void model(output bit act, output logic [31:0] c, output logic [31:0] e,
                                  output logic [31:0] t, output logic [31:0] s, output bit sel);
        bit exc [6];
        bit irq [3];
        int hit = -1;
        exc = '{fetch_mis, illegal, ecall, ebreak, load_mis, store_mis};
        irq = '{irq_ext, irq_sw, irq_tmr};
        act = 0; c = 0; e = 0; t = 0; s = 0; sel = 0;
        if (!valid) return;
        for (int i = 0; i < 6; i++) if (hit < 0 && exc[i]) hit = i;
        s = (mstatus & ~32'h1888) | (mstatus[3] ? 32'h80 : 32'h0) | 32'h1800;
        e = pc;
        if (hit >= 0) begin
            act = 1;
            c = EXC_CODE[hit];
            case (EXC_CODE[hit])
                2:       t = instr;
                3:       t = pc;
                11:      t = 0;
                default: t = addr;
            endcase
            return;
        end
`ifdef TRAP_IRQ_EN
        for (int i = 0; i < 3; i++)
            if (hit < 0 && irq[i] && mstatus[3] && mie[IRQ_CODE[i]]) hit = i;
        if (hit >= 0) begin
            act = 1;
            c = 32'h8000_0000 + IRQ_CODE[hit];
            t = 0;
            return;
        end
`endif
        if (mret) begin
            act = 1; sel = 1;
            c = mcause; e = mepc; t = mtval;
            s = (mstatus & ~32'h1888) | (mstatus[7] ? 32'h8 : 32'h0) | 32'h1880;
        end
    endfunction

    // Inputs are set before the call, at a negedge while the DUT is idle.
    task automatic run_case(input string tag);
        bit act, sel;
        logic [31:0] c, e, t, s;
        model(act, c, e, t, s, sel);
        check({tag, "_c0_ctl"}, {27'b0, we_exc, flush, busy, redirect, sel_exc_nret}, 0);
        check({tag, "_c0_cause"}, mcause_q, 0);
        @(posedge clk);
        if (!act) begin
            @(negedge clk);
            check({tag, "_noev_ctl"}, {28'b0, we_exc, flush, busy, redirect}, 0);
            clear_inputs();
            return;
        end
        for (int k = 1; k <= D + 2; k++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d_ctl", tag, k), {28'b0, we_exc, flush, busy, redirect},
                  {28'b0, 1'(k == D + 1), 1'(k <= D), 1'b1, 1'(k == D + 2)});
            check($sformatf("%s_c%0d_mcause", tag, k), mcause_q, c);
            check($sformatf("%s_c%0d_mepc", tag, k), mepc_q, e);
            check($sformatf("%s_c%0d_mtval", tag, k), mtval_q, t);
            check($sformatf("%s_c%0d_mstatus", tag, k), mstatus_q, s);
            check($sformatf("%s_c%0d_sel", tag, k), {31'b0, sel_exc_nret}, {31'b0, sel});
            if (k < D + 2) begin
                rand_inputs();
                valid = 1;
            end else begin
                clear_inputs();
            end
        end
        @(negedge clk);
        check({tag, "_idle_ctl"}, {27'b0, we_exc, flush, busy, redirect, sel_exc_nret}, 0);
        check({tag, "_idle_data"}, mcause_q | mepc_q | mtval_q | mstatus_q, 0);
    endtask

    initial begin
        clear_inputs();
        #12;
        check("rst_ctl", {27'b0, we_exc, flush, busy, redirect, sel_exc_nret}, 0);
        check("rst_data", mcause_q | mepc_q | mtval_q | mstatus_q, 0);
        rst = 1;
        @(negedge clk);

        valid = 1; pc = 32'h100; instr = 32'hFFFF_FFFF; mstatus = 32'h8; illegal = 1;
        run_case("illegal");

        valid = 1; pc = 32'h200; addr = 32'h333; instr = 32'h73; ecall = 1; load_mis = 1;
        run_case("ecall_ld");

        valid = 1; mret = 1; mstatus = 32'h1880; mepc = 32'h204; mcause = 32'h2; mtval = 32'h55;
        run_case("mret");

        valid = 1; pc = 32'h300; irq_tmr = 1; irq_ext = 1; mie = 32'h880; mstatus = 32'h8;
        run_case("irq");

        valid = 1; pc = 32'h300; irq_tmr = 1; irq_ext = 1; mie = 32'h880; mstatus = 32'h0;
        run_case("irq_mie0");

        // reset in the middle of FLUSH
        valid = 1; pc = 32'h100; instr = 32'hFFFF_FFFF; mstatus = 32'h8; illegal = 1;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        #2 rst = 0;
        #1;
        check("midrst_ctl", {27'b0, we_exc, flush, busy, redirect, sel_exc_nret}, 0);
        check("midrst_data", mcause_q | mepc_q | mtval_q | mstatus_q, 0);
        @(negedge clk);
        rst = 1;
        for (int k = 0; k < D + 3; k++) begin
            @(negedge clk);
            check($sformatf("postrst_c%0d_ctl", k), {28'b0, we_exc, flush, busy, redirect}, 0);
        end
        valid = 1; pc = 32'h400; instr = 32'h0010_0073; ebreak = 1; mstatus = 32'h88;
        run_case("after_rst");

        for (int n = 0; n < 300; n++) begin
            rand_inputs();
            run_case($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
